// File: rtl/vec_inst_dispatcher.sv
// Vector instruction dispatcher: queues scalar-side vector instructions,
// issues them one at a time and returns the completion response.
`ifndef XLEN
`define XLEN 32
`endif

module vec_inst_dispatcher #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [`XLEN-1:0]  req_instruction,
  input  logic [`XLEN-1:0]  req_rs1_data,
  input  logic [`XLEN-1:0]  req_rs2_data,
  output logic              inst_valid,
  output logic [`XLEN-1:0]  instruction,
  output logic [`XLEN-1:0]  rs1_data,
  output logic [`XLEN-1:0]  rs2_data,
  input  logic              vec_pro_ready,
  input  logic              vec_pro_ack,
  input  logic              is_vec,
  input  logic              error,
  input  logic [`XLEN-1:0]  csr_out,
  output logic              scalar_pro_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [`XLEN-1:0]  rsp_csr_out,
  output logic              rsp_error,
  output logic              rsp_illegal,
  output logic              rsp_timeout
);

  localparam int unsigned XL = `XLEN;
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned TW = $clog2(TIMEOUT) + 1;

  localparam logic [AW:0]   FULL  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PONE  = AW'(1);
  localparam logic [TW-1:0] TONE  = TW'(1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] ISSUE    = 2'd1;
  localparam logic [1:0] WAIT_ACK = 2'd2;
  localparam logic [1:0] RESP     = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [AW-1:0]   wptr_q, rptr_q;
  logic [AW:0]     cnt_q, cnt_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic [3*XL-1:0] mem_q [DEPTH];
  logic [3*XL-1:0] head;
  logic [XL-1:0]   csr_q, csr_d;
  logic            err_q, err_d;
  logic            ill_q, ill_d;
  logic            to_q, to_d;
  logic            push, pop;
  logic            in_idle, in_issue, in_wait, in_resp;

  assign in_idle  = state_q == IDLE;
  assign in_issue = state_q == ISSUE;
  assign in_wait  = state_q == WAIT_ACK;
  assign in_resp  = state_q == RESP;

  // Gated by reset so no push can be offered while the block is cleared
  assign req_ready = ~reset & (cnt_q != FULL);
  assign push      = req_valid & req_ready;
  assign pop       = in_issue & vec_pro_ready;
  assign head      = mem_q[rptr_q];

  assign inst_valid = in_issue;
  assign {instruction, rs1_data, rs2_data} = in_issue ? head : '0;

  assign scalar_pro_ready = in_wait;
  assign rsp_valid        = in_resp;
  assign rsp_csr_out      = in_resp ? csr_q : '0;
  assign rsp_error        = in_resp & err_q;
  assign rsp_illegal      = in_resp & ill_q;
  assign rsp_timeout      = in_resp & to_q;

  always_comb begin
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CONE;
      2'b01:   cnt_d = cnt_q - CONE;
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    csr_d   = csr_q;
    err_d   = err_q;
    ill_d   = ill_q;
    to_d    = to_q;
    unique case (1'b1)
      in_idle: begin
        if (cnt_q != '0) state_d = ISSUE;
      end
      in_issue: begin
        if (vec_pro_ready) begin
          state_d = WAIT_ACK;
          tmr_d   = '0;
        end
      end
      in_wait: begin
        tmr_d = tmr_q + TONE;
        // An ack landing on the last timer cycle still wins
        if (vec_pro_ack) begin
          state_d = RESP;
          csr_d   = csr_out;
          err_d   = error;
          ill_d   = ~is_vec;
          to_d    = 1'b0;
        end else if (tmr_q == TLAST) begin
          state_d = RESP;
          csr_d   = '0;
          err_d   = 1'b0;
          ill_d   = 1'b0;
          to_d    = 1'b1;
        end
      end
      in_resp: begin
        if (rsp_ready) state_d = (cnt_d != '0) ? ISSUE : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      tmr_q   <= '0;
      csr_q   <= '0;
      err_q   <= 1'b0;
      ill_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
      csr_q   <= csr_d;
      err_q   <= err_d;
      ill_q   <= ill_d;
      to_q    <= to_d;
      if (push) wptr_q <= wptr_q + PONE;
      if (pop)  rptr_q <= rptr_q + PONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= {req_instruction, req_rs1_data, req_rs2_data};
  end

endmodule

// File: tb/tb_vec_inst_dispatcher.sv
// Directed bench for vec_inst_dispatcher: vector table plus
// hand-written fill, timeout, backpressure and reset sequences.
`ifndef XLEN
`define XLEN 32
`endif

module tb_vec_inst_dispatcher;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_instruction, req_rs1_data, req_rs2_data;
  logic        inst_valid;
  logic [31:0] instruction, rs1_data, rs2_data;
  logic        vec_pro_ready, vec_pro_ack, is_vec, error;
  logic [31:0] csr_out;
  logic        scalar_pro_ready, rsp_valid, rsp_ready;
  logic [31:0] rsp_csr_out;
  logic        rsp_error, rsp_illegal, rsp_timeout;

  int n_chk  = 0;
  int n_fail = 0;

  vec_inst_dispatcher #(.DEPTH(4), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_instruction(req_instruction),
    .req_rs1_data(req_rs1_data), .req_rs2_data(req_rs2_data),
    .inst_valid(inst_valid), .instruction(instruction),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .vec_pro_ready(vec_pro_ready), .vec_pro_ack(vec_pro_ack),
    .is_vec(is_vec), .error(error), .csr_out(csr_out),
    .scalar_pro_ready(scalar_pro_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_csr_out(rsp_csr_out), .rsp_error(rsp_error),
    .rsp_illegal(rsp_illegal), .rsp_timeout(rsp_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic rst; logic rv; logic [31:0] ri, r1, r2;
    logic vr; logic ack; logic isv; logic err; logic [31:0] csr; logic rr;
    logic e_rdy; logic e_iv; logic [31:0] e_ins, e_r1, e_r2;
    logic e_spr; logic e_rv; logic [31:0] e_csr; logic [2:0] e_fl;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    int rst, int rv, int ri, int r1, int r2,
    int vr, int ack, int isv, int err, int csr, int rr,
    int erdy, int eiv, int eins, int er1, int er2,
    int espr, int erv, int ecsr, int efl);
    vec_t v;
    v.rst = rst[0]; v.rv = rv[0]; v.ri = ri; v.r1 = r1; v.r2 = r2;
    v.vr = vr[0]; v.ack = ack[0]; v.isv = isv[0]; v.err = err[0];
    v.csr = csr; v.rr = rr[0];
    v.e_rdy = erdy[0]; v.e_iv = eiv[0];
    v.e_ins = eins; v.e_r1 = er1; v.e_r2 = er2;
    v.e_spr = espr[0]; v.e_rv = erv[0]; v.e_csr = ecsr; v.e_fl = efl[2:0];
    return v;
  endfunction

  function automatic logic [134:0] outs();
    return {req_ready, inst_valid, instruction, rs1_data, rs2_data,
            scalar_pro_ready, rsp_valid, rsp_csr_out,
            rsp_error, rsp_illegal, rsp_timeout};
  endfunction

  function automatic logic [134:0] expv(vec_t v);
    return {v.e_rdy, v.e_iv, v.e_ins, v.e_r1, v.e_r2,
            v.e_spr, v.e_rv, v.e_csr, v.e_fl};
  endfunction

  task automatic chk(input string nm, input logic [134:0] got,
                     input logic [134:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic issue_one(input string nm, input logic [31:0] ins,
                           input logic [31:0] csr);
    int n = 0;
    #1;
    while (!inst_valid && n < 20) begin
      @(negedge clk); #1; n++;
    end
    chk({nm, "_issue"}, 135'({inst_valid, instruction}), 135'({1'b1, ins}));
    vec_pro_ready = 1'b1;
    @(negedge clk);
    vec_pro_ready = 1'b0;
    vec_pro_ack = 1'b1; is_vec = 1'b1; error = 1'b0; csr_out = csr;
    #1 chk({nm, "_wait"}, 135'(scalar_pro_ready), 135'(1'b1));
    @(negedge clk);
    vec_pro_ack = 1'b0; rsp_ready = 1'b1;
    #1 chk({nm, "_resp"},
           135'({rsp_valid, rsp_csr_out, rsp_error, rsp_illegal, rsp_timeout}),
           135'({1'b1, csr, 3'b000}));
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic push_at_negedge(input logic [31:0] ins);
    @(negedge clk);
    req_valid = 1'b1; req_instruction = ins;
    req_rs1_data = ins + 32'h1; req_rs2_data = ins + 32'h2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  localparam int I0 = 32'h0200_7057;

  initial begin
    logic [31:0] dv [5];
    logic bad;
    reset = 1'b1; req_valid = 1'b0;
    req_instruction = '0; req_rs1_data = '0; req_rs2_data = '0;
    vec_pro_ready = 1'b0; vec_pro_ack = 1'b0;
    is_vec = 1'b0; error = 1'b0; csr_out = '0; rsp_ready = 1'b0;

    // single instruction, then push during an ISSUE handshake
    tbl.push_back(mk(1,0,0,0,0,     0,0,0,0,0,0,     0,0,0,0,0,     0,0,0,0));
    tbl.push_back(mk(0,1,I0,8,0,    0,0,0,0,0,0,     1,0,0,0,0,     0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,     0,0,0,0,0,0,     1,0,0,0,0,     0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,     1,0,0,0,0,0,     1,1,I0,8,0,    0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,     0,0,0,0,0,0,     1,0,0,0,0,     1,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,     0,0,0,0,0,0,     1,0,0,0,0,     1,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,     0,1,1,0,8,0,     1,0,0,0,0,     1,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,     0,0,0,0,0,1,     1,0,0,0,0,     0,1,8,0));
    tbl.push_back(mk(0,0,0,0,0,     0,0,0,0,0,0,     1,0,0,0,0,     0,0,0,0));
    tbl.push_back(mk(0,1,'h11,'hA1,'hA2, 0,0,0,0,0,0, 1,0,0,0,0,    0,0,0,0));
    tbl.push_back(mk(0,1,'h22,'hB1,'hB2, 0,0,0,0,0,0, 1,0,0,0,0,    0,0,0,0));
    tbl.push_back(mk(0,1,'h33,'hC1,'hC2, 1,0,0,0,0,0,
                     1,1,'h11,'hA1,'hA2, 0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,     0,1,1,0,'h55,0,  1,0,0,0,0,     1,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,     0,0,0,0,0,1,     1,0,0,0,0,     0,1,'h55,0));
    tbl.push_back(mk(0,0,0,0,0,     0,0,0,0,0,0,     1,1,'h22,'hB1,'hB2, 0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,     1,0,0,0,0,0,     1,1,'h22,'hB1,'hB2, 0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,     0,1,1,0,'h66,0,  1,0,0,0,0,     1,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,     0,0,0,0,0,1,     1,0,0,0,0,     0,1,'h66,0));
    tbl.push_back(mk(0,0,0,0,0,     1,0,0,0,0,0,     1,1,'h33,'hC1,'hC2, 0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,     0,1,1,1,'h77,0,  1,0,0,0,0,     1,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,     0,0,0,0,0,1,     1,0,0,0,0,     0,1,'h77,4));
    tbl.push_back(mk(0,0,0,0,0,     0,0,0,0,0,0,     1,0,0,0,0,     0,0,0,0));

    repeat (2) @(posedge clk);

    foreach (tbl[i]) begin
      @(negedge clk);
      reset = tbl[i].rst; req_valid = tbl[i].rv;
      req_instruction = tbl[i].ri;
      req_rs1_data = tbl[i].r1; req_rs2_data = tbl[i].r2;
      vec_pro_ready = tbl[i].vr; vec_pro_ack = tbl[i].ack;
      is_vec = tbl[i].isv; error = tbl[i].err;
      csr_out = tbl[i].csr; rsp_ready = tbl[i].rr;
      #1 chk($sformatf("vec%0d", i), outs(), expv(tbl[i]));
    end
    @(negedge clk);
    req_valid = 1'b0; vec_pro_ready = 1'b0; vec_pro_ack = 1'b0;
    rsp_ready = 1'b0;

    // fill and stall: fifth entry held upstream, pointer wraps
    dv = '{32'hD000_0000, 32'hD000_0100, 32'hD000_0200,
           32'hD000_0300, 32'hD000_0400};
    for (int k = 0; k < 4; k++) begin
      push_at_negedge(dv[k]);
      #1 chk("fill_rdy", 135'(req_ready), 135'(1'b1));
    end
    push_at_negedge(dv[4]);
    #1 chk("full_rdy", 135'(req_ready), 135'(1'b0));
    @(negedge clk);
    vec_pro_ready = 1'b1;
    #1 chk("full_head", 135'({req_ready, inst_valid, instruction}),
           135'({1'b0, 1'b1, dv[0]}));
    @(negedge clk);
    vec_pro_ready = 1'b0;
    #1 chk("fill_wait", 135'({req_ready, scalar_pro_ready}), 135'(2'b11));
    @(negedge clk);
    req_valid = 1'b0;
    vec_pro_ack = 1'b1; is_vec = 1'b1; csr_out = 32'hD0;
    #1 chk("fill_ack", 135'(scalar_pro_ready), 135'(1'b1));
    @(negedge clk);
    vec_pro_ack = 1'b0; rsp_ready = 1'b1;
    #1 chk("fill_resp0", 135'({rsp_valid, rsp_csr_out}),
           135'({1'b1, 32'hD0}));
    @(negedge clk);
    rsp_ready = 1'b0;
    for (int k = 1; k < 5; k++)
      issue_one($sformatf("fill%0d", k), dv[k], 32'hD0 + 32'(k));

    // timeout: no ack for 16 cycles, then the queued entry issues
    push_at_negedge(32'hCAFE_0000);
    push_at_negedge(32'hCAFE_0001);
    @(negedge clk);
    req_valid = 1'b0; vec_pro_ready = 1'b1;
    #1 chk("to_issue", 135'({inst_valid, instruction}),
           135'({1'b1, 32'hCAFE_0000}));
    bad = 1'b0;
    for (int j = 1; j <= 17; j++) begin
      @(negedge clk);
      if (j == 1) vec_pro_ready = 1'b0;
      #1;
      if (j <= 16) bad = bad | ~scalar_pro_ready | rsp_valid;
    end
    chk("to_wait_hold", 135'(bad), 135'(1'b0));
    chk("to_resp", 135'({rsp_valid, rsp_timeout, rsp_illegal, rsp_error,
                         rsp_csr_out}), 135'({4'b1100, 32'h0}));
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    issue_one("to_next", 32'hCAFE_0001, 32'h1234);

    // illegal + error with ack on the last timer cycle, then backpressure
    push_at_negedge(32'hBAD0_0000);
    push_at_negedge(32'hBAD0_0001);
    @(negedge clk);
    req_valid = 1'b0; vec_pro_ready = 1'b1;
    #1 chk("ill_issue", 135'({inst_valid, instruction}),
           135'({1'b1, 32'hBAD0_0000}));
    bad = 1'b0;
    for (int j = 1; j <= 16; j++) begin
      @(negedge clk);
      if (j == 1) vec_pro_ready = 1'b0;
      if (j == 16) begin
        vec_pro_ack = 1'b1; is_vec = 1'b0; error = 1'b1;
        csr_out = 32'hBEEF;
      end
      #1 bad = bad | ~scalar_pro_ready | rsp_valid;
    end
    chk("ill_wait_hold", 135'(bad), 135'(1'b0));
    @(negedge clk);
    vec_pro_ack = 1'b0; is_vec = 1'b1; error = 1'b0; csr_out = '0;
    for (int k = 0; k < 5; k++) begin
      #1 chk($sformatf("ill_hold%0d", k),
             135'({rsp_valid, rsp_error, rsp_illegal, rsp_timeout,
                   rsp_csr_out, inst_valid}),
             135'({4'b1110, 32'hBEEF, 1'b0}));
      if (k == 4) rsp_ready = 1'b1;
      @(negedge clk);
    end
    rsp_ready = 1'b0;
    #1 chk("ill_next", 135'({inst_valid, instruction}),
           135'({1'b1, 32'hBAD0_0001}));

    // reset in WAIT_ACK with three entries queued
    req_valid = 1'b1; req_instruction = 32'hAA00_0000;
    push_at_negedge(32'hAA00_0001);
    push_at_negedge(32'hAA00_0002);
    @(negedge clk);
    req_valid = 1'b0; vec_pro_ready = 1'b1;
    #1 chk("rst_full", 135'({req_ready, inst_valid}), 135'(2'b01));
    @(negedge clk);
    vec_pro_ready = 1'b0;
    #1 chk("rst_pre_wait", 135'(scalar_pro_ready), 135'(1'b1));
    reset = 1'b1;
    @(negedge clk);
    #1 chk("rst_active", outs(), 135'(0));
    reset = 1'b0;
    #1 chk("rst_release", outs(), {1'b1, 134'(0)});
    vec_pro_ack = 1'b1; is_vec = 1'b1; csr_out = 32'h99;
    @(negedge clk);
    vec_pro_ack = 1'b0;
    bad = 1'b0;
    for (int k = 0; k < 6; k++) begin
      #1 bad = bad | rsp_valid | inst_valid | scalar_pro_ready | ~req_ready;
      @(negedge clk);
    end
    chk("rst_no_resp", 135'(bad), 135'(1'b0));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vec_inst_dispatcher.md
VEC_INST_DISPATCHER -- requirements
Module: vec_inst_dispatcher

Scalar-side issuer that buffers vector instructions from the scalar pipeline, presents them one at a time to the vector processor's valid/ready/ack interface, and returns the completion response.

Interface
REQ-001 Parameters SHALL be:
- DEPTH, default 4: power of 2, at least 2; pending-instruction FIFO entries.
- TIMEOUT, default 1024: maximum cycles to wait for ack.
- XLEN is taken from the `XLEN define.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  1  scalar pipeline offers a vector instruction.
REQ-005 req_ready  output  1  FIFO can accept an entry.
REQ-006 req_instruction, req_rs1_data, req_rs2_data  input  XLEN each  instruction and scalar operands.
REQ-007 inst_valid  output  1  an instruction is presented to the vector processor.
REQ-008 instruction, rs1_data, rs2_data  output  XLEN each  presented instruction and operands.
REQ-009 vec_pro_ready  input  1  vector processor accepts an instruction.
REQ-010 vec_pro_ack  input  1  vector processor has completed the instruction.
REQ-011 is_vec, error  input  1 each  legality and configuration-error status, sampled with the ack.
REQ-012 csr_out  input  XLEN  CSR read data, sampled with the ack.
REQ-013 scalar_pro_ready  output  1  scalar side can take the vector result.
REQ-014 rsp_valid  output  1  completion response is available.
REQ-015 rsp_ready  input  1  consumer takes the response.
REQ-016 rsp_csr_out  output  XLEN  captured CSR read data.
REQ-017 rsp_error, rsp_illegal, rsp_timeout  output  1 each  response status flags.

Function
REQ-018 The FIFO SHALL hold DEPTH entries of {instruction, rs1, rs2}.
- Read and write pointers are log2(DEPTH) bits and wrap naturally.
- The count is log2(DEPTH)+1 bits wide.
REQ-019 req_ready SHALL equal (count != DEPTH).
- Push occurs when req_valid && req_ready.
- When full, an offered entry is not stored and not dropped; req_valid stays asserted upstream.
REQ-020 A push and a pop in the same cycle SHALL leave count unchanged and update both pointers.
REQ-021 The FSM SHALL have the states IDLE, ISSUE, WAIT_ACK and RESP; only one instruction is outstanding at a time.
REQ-022 IDLE: if count != 0, the next state is ISSUE; otherwise the FSM stays in IDLE.
REQ-023 ISSUE behaviour:
- inst_valid = 1; instruction, rs1_data and rs2_data come from the FIFO head and are held stable.
- On a rising edge with vec_pro_ready = 1: pop the head, clear the timer, go to WAIT_ACK.
REQ-024 ISSUE with an empty FIFO SHALL be unreachable.
REQ-025 inst_valid, instruction, rs1_data and rs2_data SHALL be 0 outside ISSUE.
REQ-026 WAIT_ACK behaviour:
- scalar_pro_ready = 1 and the timer increments every cycle.
- On vec_pro_ack = 1: capture rsp_csr_out = csr_out, rsp_error = error, rsp_illegal = ~is_vec, rsp_timeout = 0; go to RESP.
REQ-027 In WAIT_ACK, if the timer reaches TIMEOUT-1 without an ack:
- capture rsp_csr_out = 0, rsp_error = 0, rsp_illegal = 0, rsp_timeout = 1;
- go to RESP.
- An ack arriving in that same cycle takes priority over the timeout.
REQ-028 scalar_pro_ready SHALL be 0 outside WAIT_ACK.
REQ-029 vec_pro_ack SHALL be ignored outside WAIT_ACK.
REQ-030 RESP behaviour:
- rsp_valid = 1, and all rsp_* fields are held stable.
- On rsp_ready = 1: go to ISSUE if count != 0 after this cycle's push/pop, otherwise go to IDLE.
REQ-031 Handshake latency:
- Minimum from push to inst_valid is 2 cycles (IDLE → ISSUE).
- Back-to-back issue via RESP → ISSUE incurs no IDLE cycle.
REQ-032 Pushes SHALL be accepted in every state, subject only to REQ-019.

Reset
REQ-033 While reset = 1 at a rising edge, the block SHALL clear the following:
- FSM to IDLE;
- pointers, count and timer to 0;
- all outputs to 0, including req_ready.
REQ-034 Reset mid-operation (any state) SHALL discard all FIFO contents and any in-flight response, with no ack or response delivered afterward.
REQ-035 req_ready SHALL become 1 in the first cycle after reset deasserts.

Verification
REQ-036 Single instruction: push 0x0200_7057 (rs1 = 8, rs2 = 0) with vec_pro_ready = 1 on the first ISSUE cycle; ack 3 cycles later with is_vec = 1, error = 0, csr_out = 8.
- Required: inst_valid pulses for 1 cycle.
- Required: rsp_valid = 1 with rsp_csr_out = 8 and all flags 0.
REQ-037 Fill and stall: push 5 entries with vec_pro_ready = 0.
- Required: the first 4 entries are accepted, then req_ready = 0, and the 5th is held upstream.
- Then enable vec_pro_ready and ack: entries issue in order with correct pointer wrap.
REQ-038 Simultaneous push and pop: with count = 2, push in the cycle ISSUE handshakes.
- Required: count stays 2, and the issue order is preserved.
REQ-039 Timeout: ack never arrives with TIMEOUT = 16.
- Required: rsp_timeout = 1 exactly 16 cycles after the handshake.
- Required: the next queued entry then issues.
REQ-040 Illegal instruction and response backpressure: ack with is_vec = 0, error = 1, and rsp_ready held 0 for 5 cycles.
- Required: rsp_illegal = 1 and rsp_error = 1, held stable for all 5 cycles; no new issue occurs until rsp_ready = 1.
REQ-041 Reset in WAIT_ACK with 3 entries queued.
- Required: the next cycle shows all outputs 0 except req_ready = 1 after reset deasserts.
- Required: a later ack produces no response.
